// File: rtl/rv32i_types.sv
// Shared store-queue types: the per-tag entry record and the drain FSM states.
package rv32i_types;

  typedef struct packed {
    logic        alloc;
    logic        ready;
    logic        committed;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } store_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    KICK = 2'd2
  } drain_state_t;

endpackage

// File: rtl/store_commit_fifo.sv
// In-order FIFO of committed store tags; DEPTH must be a power of 2 so the pointers wrap for free.
module store_commit_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still safe.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/store_drain_queue.sv
// Per-tag store buffer that drains committed stores to data memory one at a time, in commit order.
module store_drain_queue
  import rv32i_types::*;
#(
  parameter int TAG_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc_valid,
  input  logic [$clog2(TAG_DEPTH)-1:0] alloc_tag,
  input  logic                         exe_valid,
  input  logic [$clog2(TAG_DEPTH)-1:0] exe_tag,
  input  logic [31:0]                  exe_addr,
  input  logic [31:0]                  exe_wdata,
  input  logic [3:0]                   exe_wmask,
  input  logic                         commit_valid,
  input  logic [$clog2(TAG_DEPTH)-1:0] commit_tag,
  input  logic                         flush,
  input  logic [TAG_DEPTH-1:0]         flush_live_mask,
  output logic [31:0]                  dmem_addr,
  output logic [31:0]                  dmem_wdata,
  output logic [3:0]                   dmem_wmask,
  output logic                         dmem_req,
  input  logic                         dmem_resp,
  output logic [$clog2(TAG_DEPTH)-1:0] wb_store_tag,
  output logic                         wb_store_tag_kick,
  output logic                         drain_busy,
  output logic                         protocol_err
);

  localparam int TW = $clog2(TAG_DEPTH);

  store_entry_t  entries      [TAG_DEPTH];
  store_entry_t  entries_next [TAG_DEPTH];
  drain_state_t  state;
  logic [TW-1:0] cur_tag;
  logic [TW-1:0] fifo_dout;
  logic          fifo_empty;
  logic          fifo_full;
  logic          fifo_pop;
  logic          exe_hit;
  logic          same_tag;
  logic          commit_ok;

  assign exe_hit   = exe_valid && entries[exe_tag].alloc;
  assign same_tag  = exe_valid && commit_valid && (exe_tag == commit_tag);
  assign commit_ok = commit_valid && entries[commit_tag].alloc &&
                     entries[commit_tag].ready && !same_tag;
  assign fifo_pop  = (state == IDLE) && !fifo_empty;

  store_commit_fifo #(
    .DEPTH (TAG_DEPTH),
    .WIDTH (TW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (commit_ok),
    .pop   (fifo_pop),
    .din   (commit_tag),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Later updates override earlier ones: flush beats alloc, and the drained tag is always released.
  always_comb begin
    entries_next = entries;
    for (int unsigned i = 0; i < TAG_DEPTH; i++) begin
      if (alloc_valid && !flush && (alloc_tag == TW'(i))) begin
        entries_next[i].alloc     = 1'b1;
        entries_next[i].ready     = 1'b0;
        entries_next[i].committed = 1'b0;
      end
      if (exe_hit && (exe_tag == TW'(i))) begin
        entries_next[i].addr  = exe_addr;
        entries_next[i].wdata = exe_wdata;
        entries_next[i].wmask = exe_wmask;
        entries_next[i].ready = 1'b1;
      end
      if (commit_ok && (commit_tag == TW'(i)))
        entries_next[i].committed = 1'b1;
      if (flush && !flush_live_mask[i] && !entries[i].committed &&
          !(commit_ok && (commit_tag == TW'(i)))) begin
        entries_next[i].alloc     = 1'b0;
        entries_next[i].ready     = 1'b0;
        entries_next[i].committed = 1'b0;
      end
      if ((state == KICK) && (cur_tag == TW'(i))) begin
        entries_next[i].alloc     = 1'b0;
        entries_next[i].ready     = 1'b0;
        entries_next[i].committed = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < TAG_DEPTH; i++) entries[i] <= '0;
    end else begin
      entries <= entries_next;
    end
  end

  // The payload is captured at pop so it stays stable for the whole request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cur_tag      <= '0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_wmask   <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (commit_valid && !commit_ok) protocol_err <= 1'b1;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            cur_tag    <= fifo_dout;
            dmem_addr  <= entries[fifo_dout].addr;
            dmem_wdata <= entries[fifo_dout].wdata;
            dmem_wmask <= entries[fifo_dout].wmask;
            state      <= REQ;
          end
        end
        REQ:     if (dmem_resp) state <= KICK;
        KICK:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign dmem_req          = (state == REQ);
  assign wb_store_tag_kick = (state == KICK);
  assign wb_store_tag      = (state == KICK) ? cur_tag : '0;
  assign drain_busy        = !fifo_empty || (state != IDLE);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
                                  !(fifo_full && commit_ok && !fifo_pop));

endmodule
